vdf_sqr_ctrl: RTL and testbench

VDF_SQR_CTRL -- requirements
Module: vdf_sqr_ctrl

---
 rtl/vdf_pkg.sv | 27 ++
 rtl/vdf_wdog.sv | 30 +++
 rtl/vdf_sqr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_vdf_sqr_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdf_pkg.sv
// Shared state encoding, default parameters and state-decode helpers for the VDF squaring controller.
package vdf_pkg;

   localparam int unsigned BITS_DEF      = 1024;
   localparam int unsigned RAM_D_W_DEF   = 1024;
   localparam int unsigned RAM_DEPTH_DEF = 512;
   localparam int unsigned T_W_DEF       = 32;
   localparam int unsigned TIMEOUT_DEF   = 64;

   typedef enum logic [2:0] {
      ST_LOAD  = 3'd0,
      ST_READY = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   function automatic logic is_tbl_ok(input state_t s);
      return (s == ST_READY) || (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_DONE);
   endfunction

   function automatic logic is_busy(input state_t s);
      return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/vdf_wdog.sv
// Multiplier-result watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count reaches TIMEOUT.
module vdf_wdog #(
   parameter int unsigned TIMEOUT = vdf_pkg::TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   assign expire_c = en && (cnt == CNT_W'(TIMEOUT - 1));

   // Counter parks at the expiry value so it cannot wrap while the flag is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire_c) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vdf_sqr_ctrl.sv
// Sequencer for repeated modular squaring: loads the reduction table, then squares
// the start value T times through an external multiplier and returns the result.
module vdf_sqr_ctrl
   import vdf_pkg::*;
#(
   parameter int unsigned BITS      = BITS_DEF,
   parameter int unsigned RAM_D_W   = RAM_D_W_DEF,
   parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
   parameter int unsigned T_W       = T_W_DEF,
   parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_cfg_val,
   output logic               o_cfg_rdy,
   input  logic [RAM_D_W-1:0] i_cfg_dat,
   input  logic               i_cfg_clr,
   input  logic               i_start_val,
   output logic               o_start_rdy,
   input  logic [BITS-1:0]    i_start_x,
   input  logic [T_W-1:0]     i_start_t,
   output logic               o_res_val,
   input  logic               i_res_rdy,
   output logic [BITS-1:0]    o_res_dat,
   output logic               o_mul_val,
   input  logic               i_mul_rdy,
   output logic               o_mul_rdy,
   output logic [BITS-1:0]    o_mul_dat_a,
   output logic [BITS-1:0]    o_mul_dat_b,
   input  logic               i_mul_val,
   input  logic [BITS-1:0]    i_mul_dat,
   output logic [RAM_D_W-1:0] o_ram_d,
   output logic               o_ram_we,
   output logic               o_busy,
   output logic               o_tbl_ok,
   output logic               o_err
);

   localparam int unsigned WC_W = $clog2(RAM_DEPTH + 1);

   state_t            state, nxt;
   logic [BITS-1:0]   x, x_nxt;
   logic [T_W-1:0]    cnt, cnt_nxt;
   logic [WC_W-1:0]   wcnt, wcnt_nxt;
   logic              err_nxt;
   logic              cfg_beat, start_acc, res_acc;
   logic              wd_clr, wd_en, wd_exp;

   assign cfg_beat  = i_cfg_val && o_cfg_rdy;
   assign start_acc = i_start_val && o_start_rdy;
   assign res_acc   = o_res_val && i_res_rdy;
   assign wd_clr    = (state == ST_ISSUE);
   assign wd_en     = (state == ST_WAIT);

   vdf_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clr      (wd_clr),
      .en       (wd_en),
      .expire_c (wd_exp)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_LOAD;
      end else begin
         state <= nxt;
      end
   end

   // Next state and next datapath values.
   always_comb begin
      nxt      = state;
      x_nxt    = x;
      cnt_nxt  = cnt;
      wcnt_nxt = wcnt;
      err_nxt  = o_err;
      case (state)
         ST_LOAD: begin
            if (cfg_beat) begin
               if (wcnt == WC_W'(RAM_DEPTH - 1)) begin
                  nxt      = ST_READY;
                  wcnt_nxt = '0;
               end else begin
                  wcnt_nxt = wcnt + WC_W'(1);
               end
            end
         end
         ST_READY: begin
            // A table clear takes priority over a simultaneous job request.
            if (i_cfg_clr) begin
               nxt      = ST_LOAD;
               wcnt_nxt = '0;
               err_nxt  = 1'b0;
            end else if (start_acc) begin
               x_nxt   = i_start_x;
               cnt_nxt = i_start_t;
               nxt     = (i_start_t == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (o_mul_val && i_mul_rdy) begin
               nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_mul_val) begin
               x_nxt   = i_mul_dat;
               cnt_nxt = cnt - T_W'(1);
               nxt     = (cnt == T_W'(1)) ? ST_DONE : ST_ISSUE;
            end else if (wd_exp) begin
               nxt = ST_ERR;
            end
         end
         ST_DONE: begin
            if (res_acc) begin
               nxt = ST_READY;
            end
         end
         ST_ERR: begin
            if (i_cfg_clr) begin
               nxt      = ST_LOAD;
               wcnt_nxt = '0;
               err_nxt  = 1'b0;
            end
         end
         default: begin
            nxt = ST_LOAD;
         end
      endcase
      // A result that no WAIT is expecting is a protocol fault.
      if (i_mul_val && (state != ST_WAIT)) begin
         err_nxt = 1'b1;
      end
      if (nxt == ST_ERR) begin
         err_nxt = 1'b1;
      end
   end

   // Datapath and registered outputs, decoded from the upcoming state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x           <= '0;
         cnt         <= '0;
         wcnt        <= '0;
         o_cfg_rdy   <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_d     <= '0;
         o_start_rdy <= 1'b0;
         o_mul_val   <= 1'b0;
         o_mul_rdy   <= 1'b0;
         o_mul_dat_a <= '0;
         o_mul_dat_b <= '0;
         o_res_val   <= 1'b0;
         o_res_dat   <= '0;
         o_busy      <= 1'b0;
         o_tbl_ok    <= 1'b0;
         o_err       <= 1'b0;
      end else begin
         x           <= x_nxt;
         cnt         <= cnt_nxt;
         wcnt        <= wcnt_nxt;
         o_cfg_rdy   <= (nxt == ST_LOAD);
         o_ram_we    <= cfg_beat;
         o_ram_d     <= cfg_beat ? i_cfg_dat : o_ram_d;
         o_start_rdy <= (nxt == ST_READY);
         o_mul_val   <= (nxt == ST_ISSUE);
         o_mul_rdy   <= 1'b1;
         o_mul_dat_a <= (nxt == ST_ISSUE) ? x_nxt : '0;
         o_mul_dat_b <= (nxt == ST_ISSUE) ? x_nxt : '0;
         o_res_val   <= (nxt == ST_DONE);
         o_res_dat   <= (nxt == ST_DONE) ? x_nxt : '0;
         o_busy      <= is_busy(nxt);
         o_tbl_ok    <= is_tbl_ok(nxt);
         o_err       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_vdf_sqr_ctrl.sv
// Bench for vdf_sqr_ctrl: latency-9 squaring multiplier model, randomized jobs
// against an iterated-square reference, timeout, clear and mid-job reset scenarios.
module tb_vdf_sqr_ctrl;

   localparam int unsigned BITS      = 16;
   localparam int unsigned RAM_D_W   = 16;
   localparam int unsigned RAM_DEPTH = 4;
   localparam int unsigned T_W       = 8;
   localparam int unsigned TIMEOUT   = 20;
   localparam int unsigned LAT       = 9;
   localparam int unsigned MOD       = 65521;
   localparam logic [RAM_D_W-1:0] TBL [4] = '{16'h11, 16'h22, 16'h33, 16'h44};

   logic               i_clk = 1'b0;
   logic               i_rst_n = 1'b0;
   logic               i_cfg_val = 1'b0;
   logic               o_cfg_rdy;
   logic [RAM_D_W-1:0] i_cfg_dat = '0;
   logic               i_cfg_clr = 1'b0;
   logic               i_start_val = 1'b0;
   logic               o_start_rdy;
   logic [BITS-1:0]    i_start_x = '0;
   logic [T_W-1:0]     i_start_t = '0;
   logic               o_res_val;
   logic               i_res_rdy = 1'b0;
   logic [BITS-1:0]    o_res_dat;
   logic               o_mul_val;
   logic               i_mul_rdy = 1'b1;
   logic               o_mul_rdy;
   logic [BITS-1:0]    o_mul_dat_a;
   logic [BITS-1:0]    o_mul_dat_b;
   logic               i_mul_val = 1'b0;
   logic [BITS-1:0]    i_mul_dat = '0;
   logic [RAM_D_W-1:0] o_ram_d;
   logic               o_ram_we;
   logic               o_busy;
   logic               o_tbl_ok;
   logic               o_err;

   int checks = 0;
   int errors = 0;

   vdf_sqr_ctrl #(
      .BITS      (BITS),
      .RAM_D_W   (RAM_D_W),
      .RAM_DEPTH (RAM_DEPTH),
      .T_W       (T_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cfg_val   (i_cfg_val),
      .o_cfg_rdy   (o_cfg_rdy),
      .i_cfg_dat   (i_cfg_dat),
      .i_cfg_clr   (i_cfg_clr),
      .i_start_val (i_start_val),
      .o_start_rdy (o_start_rdy),
      .i_start_x   (i_start_x),
      .i_start_t   (i_start_t),
      .o_res_val   (o_res_val),
      .i_res_rdy   (i_res_rdy),
      .o_res_dat   (o_res_dat),
      .o_mul_val   (o_mul_val),
      .i_mul_rdy   (i_mul_rdy),
      .o_mul_rdy   (o_mul_rdy),
      .o_mul_dat_a (o_mul_dat_a),
      .o_mul_dat_b (o_mul_dat_b),
      .i_mul_val   (i_mul_val),
      .i_mul_dat   (i_mul_dat),
      .o_ram_d     (o_ram_d),
      .o_ram_we    (o_ram_we),
      .o_busy      (o_busy),
      .o_tbl_ok    (o_tbl_ok),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [BITS-1:0] ref_sq(input logic [BITS-1:0] v);
      longint unsigned p;
      p = 64'(v) * 64'(v);
      return BITS'(p % 64'(MOD));
   endfunction

   // Multiplier model: result of a handshake in cycle k is presented in cycle k+LAT.
   int               cyc = 0;
   int               due_q[$];
   logic [BITS-1:0]  dat_q[$];
   int               res_seq = 0;
   int               drop_at = -1;

   always @(posedge i_clk) begin
      if (o_mul_val && i_mul_rdy) begin
         due_q.push_back(cyc + int'(LAT));
         dat_q.push_back(ref_sq(o_mul_dat_a) & ref_sq(o_mul_dat_b));
      end
      cyc++;
      #1;
      i_mul_val = 1'b0;
      i_mul_dat = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         res_seq++;
         if (res_seq != drop_at) begin
            i_mul_val = 1'b1;
            i_mul_dat = dat_q[0];
         end
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end
   end

   logic [RAM_D_W-1:0] ram_q[$];
   always @(posedge i_clk) begin
      if (o_ram_we === 1'b1) ram_q.push_back(o_ram_d);
   end

   task automatic load_tbl(input bit clr_in_gap);
      int n;
      ram_q.delete();
      n = 0;
      while (o_cfg_rdy !== 1'b1 && n < 20) begin step(); n++; end
      chk("load_cfg_rdy", 64'(o_cfg_rdy), 64'(1));
      for (int i = 0; i < 4; i++) begin
         if (i == 3) chk("tbl_ok_early", 64'(o_tbl_ok), 64'(0));
         i_cfg_val = 1'b1;
         i_cfg_dat = TBL[i];
         step();
         i_cfg_val = 1'b0;
         if (i == 1) begin
            i_cfg_clr = clr_in_gap;
            step();
            i_cfg_clr = 1'b0;
         end
      end
      chk("tbl_ok", 64'(o_tbl_ok), 64'(1));
      chk("cfg_rdy_off", 64'(o_cfg_rdy), 64'(0));
      chk("start_rdy_on", 64'(o_start_rdy), 64'(1));
      step();
      chk("we_count", 64'(ram_q.size()), 64'(4));
      for (int i = 0; i < 4 && i < ram_q.size(); i++) chk("ram_word", 64'(ram_q[i]), 64'(TBL[i]));
   endtask

   task automatic start_job(input logic [BITS-1:0] x, input int t);
      int n;
      n = 0;
      while (o_start_rdy !== 1'b1 && n < 50) begin step(); n++; end
      chk("start_rdy", 64'(o_start_rdy), 64'(1));
      i_start_val = 1'b1;
      i_start_x   = x;
      i_start_t   = T_W'(t);
      step();
      i_start_val = 1'b0;
   endtask

   task automatic run_job(input logic [BITS-1:0] x, input int t, input bit timing,
                          input int hold, input bit rnd);
      logic [BITS-1:0] xs[$];
      logic [BITS-1:0] op_a[$];
      logic [BITS-1:0] op_b[$];
      int              iss[$];
      int              c;
      bit              got;
      xs.push_back(x);
      for (int i = 0; i < t; i++) xs.push_back(ref_sq(xs[i]));
      start_job(x, t);
      c   = 1;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         i_mul_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_mul_val && i_mul_rdy) begin
            iss.push_back(c);
            op_a.push_back(o_mul_dat_a);
            op_b.push_back(o_mul_dat_b);
         end
         if (o_res_val) got = 1'b1;
         else begin step(); c++; end
      end
      i_mul_rdy = 1'b1;
      chk("res_seen", 64'(got), 64'(1));
      chk("n_issue", 64'(op_a.size()), 64'(t));
      for (int i = 0; i < t && i < op_a.size(); i++) begin
         chk("op_a", 64'(op_a[i]), 64'(xs[i]));
         chk("op_b", 64'(op_b[i]), 64'(xs[i]));
         if (timing) chk("issue_cyc", 64'(iss[i]), 64'(1 + i * int'(LAT + 1)));
      end
      if (timing) chk("res_cyc", 64'(c), 64'(t * int'(LAT + 1) + 1));
      chk("res_dat", 64'(o_res_dat), 64'(xs[t]));
      for (int h = 0; h < hold; h++) begin
         chk("hold_val", 64'(o_res_val), 64'(1));
         chk("hold_dat", 64'(o_res_dat), 64'(xs[t]));
         chk("hold_start_rdy", 64'(o_start_rdy), 64'(0));
         step();
      end
      i_res_rdy = 1'b1;
      step();
      i_res_rdy = 1'b0;
      chk("res_consumed", 64'(o_res_val), 64'(0));
      chk("ready_again", 64'(o_start_rdy), 64'(1));
      chk("no_err", 64'(o_err), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      i_rst_n = 1'b0;
      repeat (3) step();
      chk("rst_cfg_rdy", 64'(o_cfg_rdy), 64'(0));
      chk("rst_tbl_ok", 64'(o_tbl_ok), 64'(0));
      chk("rst_start_rdy", 64'(o_start_rdy), 64'(0));
      chk("rst_res_val", 64'(o_res_val), 64'(0));
      chk("rst_mul_val", 64'(o_mul_val), 64'(0));
      chk("rst_ram_we", 64'(o_ram_we), 64'(0));
      chk("rst_err", 64'(o_err), 64'(0));
      chk("rst_res_dat", 64'(o_res_dat), 64'(0));
      chk("rst_mul_dat", 64'(o_mul_dat_a), 64'(0));
      i_rst_n = 1'b1;
      chk("cfg_rdy_pre", 64'(o_cfg_rdy), 64'(0));
      step();
      chk("cfg_rdy_rise", 64'(o_cfg_rdy), 64'(1));
      chk("mul_rdy", 64'(o_mul_rdy), 64'(1));

      load_tbl(1'b1);
      run_job(16'd3, 3, 1'b1, 7, 1'b0);
      run_job(16'd5, 0, 1'b1, 0, 1'b0);
      for (int k = 0; k < 6; k++)
         run_job(BITS'($urandom), int'($urandom_range(1, 5)), (k % 2) == 0,
                 int'($urandom_range(0, 3)), (k % 2) == 1);

      // Second multiplier result is lost: watchdog must fire 20 cycles into WAIT.
      drop_at = res_seq + 2;
      start_job(16'd2, 4);
      repeat (30) step();
      chk("err_pre_tmo", 64'(o_err), 64'(0));
      chk("busy_wait", 64'(o_busy), 64'(1));
      step();
      chk("err_tmo", 64'(o_err), 64'(1));
      chk("err_tbl_ok", 64'(o_tbl_ok), 64'(0));
      chk("err_busy", 64'(o_busy), 64'(0));
      chk("err_start_rdy", 64'(o_start_rdy), 64'(0));
      chk("err_mul_val", 64'(o_mul_val), 64'(0));
      chk("err_res_val", 64'(o_res_val), 64'(0));
      repeat (3) step();
      chk("err_sticky", 64'(o_err), 64'(1));
      chk("err_cfg_rdy", 64'(o_cfg_rdy), 64'(0));
      i_cfg_clr = 1'b1;
      step();
      i_cfg_clr = 1'b0;
      chk("clr_to_load", 64'(o_cfg_rdy), 64'(1));
      chk("clr_err", 64'(o_err), 64'(0));
      drop_at = -1;

      // Reset during WAIT, with the in-flight result arriving afterwards.
      load_tbl(1'b0);
      start_job(16'd7, 2);
      repeat (3) step();
      chk("wait_busy", 64'(o_busy), 64'(1));
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(o_busy), 64'(0));
      chk("mid_rst_tbl_ok", 64'(o_tbl_ok), 64'(0));
      chk("mid_rst_cfg_rdy", 64'(o_cfg_rdy), 64'(0));
      chk("mid_rst_start_rdy", 64'(o_start_rdy), 64'(0));
      chk("mid_rst_mul_val", 64'(o_mul_val), 64'(0));
      chk("mid_rst_res_val", 64'(o_res_val), 64'(0));
      step();
      step();
      i_rst_n = 1'b1;
      step();
      chk("post_rst_cfg_rdy", 64'(o_cfg_rdy), 64'(1));
      step();
      step();
      chk("late_err_pre", 64'(o_err), 64'(0));
      step();
      step();
      chk("late_err", 64'(o_err), 64'(1));
      load_tbl(1'b0);
      chk("err_after_reload", 64'(o_err), 64'(1));
      i_cfg_clr = 1'b1;
      step();
      i_cfg_clr = 1'b0;
      chk("ready_clr_load", 64'(o_cfg_rdy), 64'(1));
      chk("ready_clr_err", 64'(o_err), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
